// File: rtl/tblink_rpc_invoke_initiator_if.sv
// Handshake bundle between the invoke initiator and its request/tx/rx/response partners.
// master: the initiator side; slave: the environment driving requests and byte streams.
interface tblink_rpc_invoke_initiator_if #(
    parameter int unsigned MAX_PARAMS = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic [7:0]              req_method_id;
    logic [3:0]              req_nparams;
    logic [32*MAX_PARAMS-1:0] req_params;

    logic [7:0]              tx_dat;
    logic                    tx_valid;
    logic                    tx_ready;

    logic [7:0]              rx_dat;
    logic                    rx_valid;
    logic                    rx_ready;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [7:0]              rsp_status;
    logic [31:0]             rsp_retval;
    logic                    rsp_err;

    modport master (
        input  req_valid, req_method_id, req_nparams, req_params,
        input  tx_ready, rx_dat, rx_valid, rsp_ready,
        output req_ready, tx_dat, tx_valid, rx_ready,
        output rsp_valid, rsp_status, rsp_retval, rsp_err
    );

    modport slave (
        output req_valid, req_method_id, req_nparams, req_params,
        output tx_ready, rx_dat, rx_valid, rsp_ready,
        input  req_ready, tx_dat, tx_valid, rx_ready,
        input  rsp_valid, rsp_status, rsp_retval, rsp_err
    );
endinterface

// File: rtl/tblink_rpc_invoke_initiator.sv
// TBLink RPC invoke initiator: serialises one method call into a framed byte
// stream, then parses the matching response frame. One call outstanding.
// Optional response timeout: define TBLINK_RPC_INVOKE_TIMEOUT_EN.
module tblink_rpc_invoke_initiator #(
    parameter int unsigned MAX_PARAMS = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    tblink_rpc_invoke_initiator_if.master bus_if,
    output logic busy_o
);

    localparam int unsigned PW     = 32 * MAX_PARAMS;
    localparam int unsigned IDX_W  = 6;
    localparam logic [3:0]  MAX_NP = 4'(MAX_PARAMS);

`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_HDR,
        S_TX_PARAM,
        S_TX_CSUM,
        S_RX_HUNT,
        S_RX_BODY,
        S_RSP
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        call_id_q, call_id_d;
    logic [7:0]        method_q, method_d;
    logic [3:0]        nparams_q, nparams_d;
    logic [PW-1:0]     params_q, params_d;
    logic [7:0]        tx_csum_q, tx_csum_d;
    logic [7:0]        rx_csum_q, rx_csum_d;
    logic              id_ok_q, id_ok_d;

    logic              req_ready_q, req_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_dat_q, tx_dat_d;
    logic              rx_ready_q, rx_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_status_q, rsp_status_d;
    logic [31:0]       rsp_retval_q, rsp_retval_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    logic tx_fire;
    logic rx_fire;
    logic rsp_fire;
    logic [IDX_W-1:0] param_last;

    assign tx_fire    = tx_valid_q && bus_if.tx_ready;
    assign rx_fire    = rx_ready_q && bus_if.rx_valid;
    assign rsp_fire   = rsp_valid_q && bus_if.rsp_ready;
    assign param_last = {nparams_q, 2'b00} - 6'd1;

    // Next-state, datapath and next-cycle output decode
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        call_id_d    = call_id_q;
        method_d     = method_q;
        nparams_d    = nparams_q;
        params_d     = params_q;
        tx_csum_d    = tx_csum_q;
        rx_csum_d    = rx_csum_q;
        id_ok_d      = id_ok_q;
        rsp_status_d = rsp_status_q;
        rsp_retval_d = rsp_retval_q;
        rsp_err_d    = rsp_err_q;
        req_ready_d  = 1'b0;
        tx_valid_d   = 1'b0;
        tx_dat_d     = 8'h00;
        rx_ready_d   = 1'b0;
        rsp_valid_d  = 1'b0;
        busy_d       = 1'b0;
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus_if.req_valid) begin
                    method_d  = bus_if.req_method_id;
                    nparams_d = (bus_if.req_nparams > MAX_NP) ? MAX_NP : bus_if.req_nparams;
                    params_d  = bus_if.req_params;
                    tx_csum_d = 8'h00;
                    idx_d     = '0;
                    state_d   = S_TX_HDR;
                end
            end
            S_TX_HDR: begin
                if (tx_fire) begin
                    // SYNC is excluded from the checksum
                    if (idx_q != 6'd0) begin
                        tx_csum_d = tx_csum_q ^ tx_dat_q;
                    end
                    if (idx_q == 6'd3) begin
                        idx_d   = '0;
                        state_d = (nparams_q == 4'd0) ? S_TX_CSUM : S_TX_PARAM;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_TX_PARAM: begin
                if (tx_fire) begin
                    tx_csum_d = tx_csum_q ^ tx_dat_q;
                    if (idx_q == param_last) begin
                        idx_d   = '0;
                        state_d = S_TX_CSUM;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_TX_CSUM: begin
                if (tx_fire) begin
                    idx_d   = '0;
                    state_d = S_RX_HUNT;
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_RX_HUNT: begin
                if (rx_fire && (bus_if.rx_dat == SYNC_BYTE)) begin
                    idx_d     = '0;
                    rx_csum_d = 8'h00;
                    state_d   = S_RX_BODY;
                end
            end
            S_RX_BODY: begin
                if (rx_fire) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q != 6'd6) begin
                        rx_csum_d = rx_csum_q ^ bus_if.rx_dat;
                    end
                    case (idx_q)
                        6'd0: id_ok_d = (bus_if.rx_dat == call_id_q);
                        6'd1: rsp_status_d = bus_if.rx_dat;
                        6'd2: rsp_retval_d[7:0]   = bus_if.rx_dat;
                        6'd3: rsp_retval_d[15:8]  = bus_if.rx_dat;
                        6'd4: rsp_retval_d[23:16] = bus_if.rx_dat;
                        6'd5: rsp_retval_d[31:24] = bus_if.rx_dat;
                        6'd6: begin
                            // A frame for another call is swallowed whole before re-hunting
                            if (id_ok_q) begin
                                rsp_err_d = (rx_csum_q != bus_if.rx_dat);
                                state_d   = S_RSP;
                            end else begin
                                state_d   = S_RX_HUNT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RSP: begin
                if (rsp_fire) begin
                    call_id_d = call_id_q + 8'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
        // Counter spans the whole receive phase of one call, including re-hunts
        if ((state_q == S_RX_HUNT) || (state_q == S_RX_BODY)) begin
            if (tmo_q == TMO_LAST) begin
                state_d      = S_RSP;
                rsp_err_d    = 1'b1;
                rsp_status_d = 8'hFF;
                rsp_retval_d = 32'h0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        tx_valid_d  = (state_d == S_TX_HDR) || (state_d == S_TX_PARAM) || (state_d == S_TX_CSUM);
        rx_ready_d  = (state_d == S_RX_HUNT) || (state_d == S_RX_BODY);
        rsp_valid_d = (state_d == S_RSP);

        case (state_d)
            S_TX_HDR: begin
                case (idx_d[1:0])
                    2'd0: tx_dat_d = SYNC_BYTE;
                    2'd1: tx_dat_d = call_id_d;
                    2'd2: tx_dat_d = method_d;
                    default: tx_dat_d = {4'h0, nparams_d};
                endcase
            end
            S_TX_PARAM: tx_dat_d = 8'(params_d >> {idx_d, 3'b000});
            S_TX_CSUM:  tx_dat_d = tx_csum_d;
            default:    tx_dat_d = 8'h00;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            call_id_q    <= 8'h00;
            method_q     <= 8'h00;
            nparams_q    <= 4'h0;
            params_q     <= '0;
            tx_csum_q    <= 8'h00;
            rx_csum_q    <= 8'h00;
            id_ok_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            tx_valid_q   <= 1'b0;
            tx_dat_q     <= 8'h00;
            rx_ready_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 8'h00;
            rsp_retval_q <= 32'h0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            call_id_q    <= call_id_d;
            method_q     <= method_d;
            nparams_q    <= nparams_d;
            params_q     <= params_d;
            tx_csum_q    <= tx_csum_d;
            rx_csum_q    <= rx_csum_d;
            id_ok_q      <= id_ok_d;
            req_ready_q  <= req_ready_d;
            tx_valid_q   <= tx_valid_d;
            tx_dat_q     <= tx_dat_d;
            rx_ready_q   <= rx_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_retval_q <= rsp_retval_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus_if.req_ready  = req_ready_q;
    assign bus_if.tx_valid   = tx_valid_q;
    assign bus_if.tx_dat     = tx_dat_q;
    assign bus_if.rx_ready   = rx_ready_q;
    assign bus_if.rsp_valid  = rsp_valid_q;
    assign bus_if.rsp_status = rsp_status_q;
    assign bus_if.rsp_retval = rsp_retval_q;
    assign bus_if.rsp_err    = rsp_err_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_tblink_rpc_invoke_initiator.sv
// Scoreboard bench for the invoke initiator: expected tx bytes and responses are
// queued when each call is issued; a negedge monitor pops and compares them.
module tb_tblink_rpc_invoke_initiator;

    localparam int unsigned MAXP = 4;
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
    // Long enough that randomised response frames with gaps never trip it
    localparam int unsigned TMO = 64;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    tblink_rpc_invoke_initiator_if #(.MAX_PARAMS(MAXP)) bus ();

    tblink_rpc_invoke_initiator #(
        .MAX_PARAMS(MAXP),
        .SYNC_BYTE (8'hA5)
`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(bus),
        .busy_o(busy)
    );

    typedef struct {
        logic [7:0] b;
        bit         first;
    } txe_t;

    typedef struct {
        logic [7:0]  status;
        logic [31:0] retval;
        bit          err;
        bit          chk_vals;
    } rspe_t;

    txe_t       exp_tx[$];
    rspe_t      exp_rsp[$];
    logic [7:0] rx_q[$];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_id    = 8'h00;
    int         tx_mode = 0;
    bit         rx_gaps = 1'b1;

    int         neg_n = 0;
    int         last_fire_n = 0;
    int         last_tx_n = 0;
    int         rsp_rise_n = 0;
    int         tx_seen = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    bit         prev_rv = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // tx_ready pattern: 0 = always ready, 1 = toggling, 2 = random
    always begin
        @(posedge clk);
        #1;
        case (tx_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            default: bus.tx_ready = ($urandom % 3) != 0;
        endcase
        bus.rsp_ready = ($urandom % 2) != 0;
    end

    // Response byte source: holds the head byte until consumed
    always begin
        bit take;
        @(negedge clk);
        take = bus.rx_valid && bus.rx_ready;
        @(posedge clk);
        #1;
        if (take && rx_q.size() > 0) void'(rx_q.pop_front());
        if (rx_q.size() > 0) begin
            bus.rx_dat   = rx_q[0];
            bus.rx_valid = !rx_gaps || (($urandom % 4) != 0);
        end else begin
            bus.rx_valid = 1'b0;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        txe_t  e;
        rspe_t r;
        neg_n++;
        if (rst) begin
            prev_stall = 1'b0;
            prev_rv    = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) last_fire_n = neg_n;
            if (prev_stall) begin
                check("tx_hold_valid", 64'(bus.tx_valid), 64'(1));
                check("tx_hold_dat", 64'(bus.tx_dat), 64'(prev_dat));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_seen++;
                if (exp_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_extra: got byte %0h, expected none", bus.tx_dat);
                end else begin
                    e = exp_tx.pop_front();
                    check(e.first ? "tx_sync" : "tx_byte", 64'(bus.tx_dat), 64'(e.b));
                    if (tx_mode == 0) check("tx_contig", 64'(neg_n), 64'(last_fire_n + 1));
                end
                last_fire_n = neg_n;
                last_tx_n   = neg_n;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_dat   = bus.tx_dat;
            if (bus.rsp_valid && !prev_rv) rsp_rise_n = neg_n;
            prev_rv = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_extra: got status %0h retval %0h, expected none",
                             bus.rsp_status, bus.rsp_retval);
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_err", 64'(bus.rsp_err), 64'(r.err));
                    check("rsp_busy", 64'(busy), 64'(1));
                    if (r.chk_vals) begin
                        check("rsp_status", 64'(bus.rsp_status), 64'(r.status));
                        check("rsp_retval", 64'(bus.rsp_retval), 64'(r.retval));
                    end
                end
            end
        end
    end

    // Queue the expected frame/response for one call and hand the request over
    task automatic issue_call(input logic [7:0] meth, input logic [3:0] np,
                              input logic [32*MAXP-1:0] prm, input int junk,
                              input bit wrong, input bit corrupt, input bit no_rsp,
                              input logic [7:0] st, input logic [31:0] rv);
        int         n_eff;
        logic [7:0] cs;
        logic [7:0] b;
        txe_t       e;
        rspe_t      r;
        bit         ok;
        n_eff = (int'(np) > MAXP) ? MAXP : int'(np);
        e.first = 1'b1; e.b = 8'hA5; exp_tx.push_back(e);
        e.first = 1'b0;
        e.b = m_id;         exp_tx.push_back(e);
        e.b = meth;         exp_tx.push_back(e);
        e.b = 8'(n_eff);    exp_tx.push_back(e);
        cs = m_id ^ meth ^ 8'(n_eff);
        for (int k = 0; k < n_eff; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = prm[32*k + 8*j +: 8];
                cs ^= b;
                e.b = b;
                exp_tx.push_back(e);
            end
        end
        e.b = cs;
        exp_tx.push_back(e);

        if (no_rsp) begin
            r.status = 8'hFF; r.retval = 32'h0; r.err = 1'b1; r.chk_vals = 1'b1;
        end else begin
            for (int j = 0; j < junk; j++) begin
                do b = 8'($urandom); while (b == 8'hA5);
                rx_q.push_back(b);
            end
            if (wrong) begin
                rx_q.push_back(8'hA5);
                rx_q.push_back(m_id ^ 8'($urandom_range(1, 255)));
                for (int j = 0; j < 6; j++) rx_q.push_back(8'($urandom));
            end
            rx_q.push_back(8'hA5);
            rx_q.push_back(m_id);
            rx_q.push_back(st);
            cs = m_id ^ st;
            for (int j = 0; j < 4; j++) begin
                b = rv[8*j +: 8];
                cs ^= b;
                rx_q.push_back(b);
            end
            if (corrupt) cs ^= 8'($urandom_range(1, 255));
            rx_q.push_back(cs);
            r.status = st; r.retval = rv; r.err = corrupt; r.chk_vals = !corrupt;
        end
        exp_rsp.push_back(r);
        m_id = m_id + 8'd1;

        @(posedge clk);
        #1;
        bus.req_valid     = 1'b1;
        bus.req_method_id = meth;
        bus.req_nparams   = np;
        bus.req_params    = prm;
        ok = 1'b0;
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (exp_rsp.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("call_timeout", 64'(0), 64'(1));
            exp_rsp.delete();
            exp_tx.delete();
            rx_q.delete();
        end
    endtask

    task automatic check_reset_state();
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
        check("rst_tx_dat", 64'(bus.tx_dat), 64'(0));
        check("rst_rx_ready", 64'(bus.rx_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_status", 64'(bus.rsp_status), 64'(0));
        check("rst_rsp_retval", 64'(bus.rsp_retval), 64'(0));
        check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [32*MAXP-1:0] prm;
        bus.req_valid     = 1'b0;
        bus.req_method_id = 8'h00;
        bus.req_nparams   = 4'h0;
        bus.req_params    = '0;
        bus.tx_ready      = 1'b1;
        bus.rx_valid      = 1'b0;
        bus.rx_dat        = 8'h00;
        bus.rsp_ready     = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single-parameter call, sink always ready
        tx_mode = 0;
        prm = '0;
        prm[31:0] = 32'h11223344;
        issue_call(8'h03, 4'd1, prm, 0, 1'b0, 1'b0, 1'b0, 8'h00, 32'hDEADBEEF);
        wait_done();

        // No parameters, toggling sink
        tx_mode = 1;
        issue_call(8'h07, 4'd0, prm, 0, 1'b0, 1'b0, 1'b0, 8'h12, 32'h0BADF00D);
        wait_done();

        // Stale frame for another call id ahead of the real one, plus junk
        tx_mode = 2;
        issue_call(8'h21, 4'd2, {$urandom, $urandom, $urandom, $urandom}, 3,
                   1'b1, 1'b0, 1'b0, 8'h5A, 32'hCAFEF00D);
        wait_done();

        // Corrupted response checksum, then a normal call
        issue_call(8'h09, 4'd1, prm, 0, 1'b0, 1'b1, 1'b0, 8'h01, 32'h12345678);
        wait_done();
        issue_call(8'h0A, 4'd3, {$urandom, $urandom, $urandom, $urandom}, 0,
                   1'b0, 1'b0, 1'b0, 8'h02, 32'h87654321);
        wait_done();

        // Oversized parameter count is clamped
        tx_mode = 0;
        issue_call(8'h44, 4'd15, {$urandom, $urandom, $urandom, $urandom}, 1,
                   1'b0, 1'b0, 1'b0, 8'h03, 32'hA5A5A5A5);
        wait_done();

        // Asynchronous reset in the middle of the parameter bytes
        tx_seen = 0;
        issue_call(8'h33, 4'd3, {$urandom, $urandom, $urandom, $urandom}, 0,
                   1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int c = 0; c < 200 && tx_seen < 6; c++) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_tx_valid", 64'(bus.tx_valid), 64'(0));
        check("arst_req_ready", 64'(bus.req_ready), 64'(1));
        check("arst_busy", 64'(busy), 64'(0));
        exp_tx.delete();
        exp_rsp.delete();
        rx_q.delete();
        m_id = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        issue_call(8'h55, 4'd1, prm, 0, 1'b0, 1'b0, 1'b0, 8'h77, 32'h00C0FFEE);
        wait_done();

        // Randomised back-to-back calls, enough to wrap the call id
        for (int i = 0; i < 260; i++) begin
            tx_mode = (i % 7 == 0) ? 0 : 2;
            for (int k = 0; k < int'(MAXP); k++) prm[32*k +: 32] = $urandom;
            issue_call(8'($urandom), 4'($urandom), prm, $urandom_range(0, 3),
                       ($urandom % 5) == 0, ($urandom % 6) == 0, 1'b0,
                       8'($urandom), $urandom);
            wait_done();
        end

`ifdef TBLINK_RPC_INVOKE_TIMEOUT_EN
        // No response at all: timeout error after TMO receive cycles
        tx_mode = 0;
        issue_call(8'h66, 4'd0, prm, 0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        wait_done();
        check("tmo_latency", 64'(rsp_rise_n - last_tx_n), 64'(TMO + 1));
`endif

        repeat (4) @(posedge clk);
        check("tx_queue_drained", 64'(exp_tx.size()), 64'(0));
        check("rx_queue_drained", 64'(rx_q.size()), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so the run always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1);
    end

endmodule
